// File: rtl/rv_mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between the fetch and data
// ports; one transaction outstanding at a time, with a watchdog on silent memory.
module rv_mem_arbiter #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk_i,
    input  logic              arstn_i,
    input  logic              instr_req_i,
    input  logic [XLEN-1:0]   instr_addr_i,
    output logic              instr_rvalid_o,
    output logic [XLEN-1:0]   instr_rdata_o,
    input  logic              data_req_i,
    input  logic              data_we_i,
    input  logic [XLEN/8-1:0] data_be_i,
    input  logic [XLEN-1:0]   data_addr_i,
    input  logic [XLEN-1:0]   data_wdata_i,
    output logic              data_rvalid_o,
    output logic [XLEN-1:0]   data_rdata_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [XLEN/8-1:0] mem_be_o,
    output logic [XLEN-1:0]   mem_addr_o,
    output logic [XLEN-1:0]   mem_wdata_o,
    input  logic              mem_rvalid_i,
    input  logic [XLEN-1:0]   mem_rdata_i,
    output logic              bus_err_o
);
    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, WAIT_I, WAIT_D} state_t;

    state_t     state, state_nxt;
    logic       last_grant;   // 1 when the data port won the previous grant
    logic [7:0] wd_cnt;
    logic       grant_i, grant_d, timeout;

    assign timeout = (wd_cnt == TIMEOUT_CNT);

    always_comb begin
        state_nxt = state;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        case (state)
            IDLE: begin
                if (instr_req_i && (!data_req_i || last_grant)) begin
                    grant_i   = 1'b1;
                    state_nxt = WAIT_I;
                end else if (data_req_i) begin
                    grant_d   = 1'b1;
                    state_nxt = WAIT_D;
                end
            end
            WAIT_I, WAIT_D: begin
                if (mem_rvalid_i || timeout) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            wd_cnt     <= '0;
            bus_err_o  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (grant_i || grant_d) begin
                last_grant <= grant_d;
                wd_cnt     <= '0;
            end else if (state != IDLE && !mem_rvalid_i) begin
                wd_cnt <= wd_cnt + 8'd1;
            end
            // A response arriving on the timeout cycle wins over the abort
            if (state != IDLE && timeout && !mem_rvalid_i) bus_err_o <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_be_o    <= '0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
        end else begin
            mem_req_o <= grant_i || grant_d;
            if (grant_i) begin
                mem_we_o    <= 1'b0;
                mem_be_o    <= '1;
                mem_addr_o  <= instr_addr_i;
                mem_wdata_o <= '0;
            end else if (grant_d) begin
                mem_we_o    <= data_we_i;
                mem_be_o    <= data_be_i;
                mem_addr_o  <= data_addr_i;
                mem_wdata_o <= data_wdata_i;
            end
        end
    end

    assign instr_rvalid_o = (state == WAIT_I) && (mem_rvalid_i || timeout);
    assign instr_rdata_o  = (state == WAIT_I && mem_rvalid_i) ? mem_rdata_i : '0;
    assign data_rvalid_o  = (state == WAIT_D) && (mem_rvalid_i || timeout);
    assign data_rdata_o   = (state == WAIT_D && mem_rvalid_i) ? mem_rdata_i : '0;
endmodule

// File: tb/tb_rv_mem_arbiter.sv
// Bench for rv_mem_arbiter: per-cycle vector table, hand-written corner sequences,
// and a randomized run against a transaction-level reference model.
module tb_rv_mem_arbiter;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        arstn;
    logic        ireq, dreq, dwe, mrv;
    logic [31:0] iaddr, daddr, dwdata, mrdata;
    logic [3:0]  dbe;
    logic        irv, drv, mreq, mwe, err;
    logic [31:0] ird, drd, maddr, mwdata;
    logic [3:0]  mbe;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rv_mem_arbiter #(.XLEN(32), .TIMEOUT(TO)) dut (
        .clk_i(clk), .arstn_i(arstn),
        .instr_req_i(ireq), .instr_addr_i(iaddr),
        .instr_rvalid_o(irv), .instr_rdata_o(ird),
        .data_req_i(dreq), .data_we_i(dwe), .data_be_i(dbe),
        .data_addr_i(daddr), .data_wdata_i(dwdata),
        .data_rvalid_o(drv), .data_rdata_o(drd),
        .mem_req_o(mreq), .mem_we_o(mwe), .mem_be_o(mbe),
        .mem_addr_o(maddr), .mem_wdata_o(mwdata),
        .mem_rvalid_i(mrv), .mem_rdata_i(mrdata),
        .bus_err_o(err)
    );

    typedef struct {
        string       name;
        logic        ireq;
        logic [31:0] iaddr;
        logic        dreq, dwe;
        logic [3:0]  dbe;
        logic [31:0] daddr, dwdata;
        logic        mrv;
        logic [31:0] mrd;
        logic [136:0] exp;
    } vec_t;

    function automatic logic [136:0] pk(input logic q, input logic we, input logic [3:0] be,
                                        input logic [31:0] a, input logic [31:0] wd,
                                        input logic iv, input logic [31:0] id,
                                        input logic dv, input logic [31:0] dd, input logic e);
        return {q, we, be, a, wd, iv, id, dv, dd, e};
    endfunction

    function automatic logic [136:0] outs();
        return pk(mreq, mwe, mbe, maddr, mwdata, irv, ird, drv, drd, err);
    endfunction

    function automatic vec_t mk(input string n, input logic iq, input logic [31:0] ia,
                                input logic dq, input logic w, input logic [3:0] b,
                                input logic [31:0] da, input logic [31:0] dw,
                                input logic rv, input logic [31:0] rd, input logic [136:0] e);
        vec_t v;
        v.name = n; v.ireq = iq; v.iaddr = ia; v.dreq = dq; v.dwe = w; v.dbe = b;
        v.daddr = da; v.dwdata = dw; v.mrv = rv; v.mrd = rd; v.exp = e;
        return v;
    endfunction

    task automatic chk(input string name, input logic [136:0] got, input logic [136:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        ireq = 0; iaddr = 0; dreq = 0; dwe = 0; dbe = 0; daddr = 0; dwdata = 0;
        mrv = 0; mrdata = 0;
    endtask

    task automatic do_reset();
        arstn = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 arstn = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        vec_t tbl[8];
        int owner, issue_cyc, cyc, age;
        logic last_data, ipend, dpend, fin;
        logic m_req, m_we, m_err, e_irv, e_drv;
        logic [3:0]  m_be, pbe;
        logic [31:0] m_addr, m_wdata, e_ird, e_drd, pia, pda, pwd;
        logic        pwe;

        tbl[0] = mk("fetch_req", 1, 32'h100, 0, 0, 0, 0, 0, 0, 0,
                    pk(0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0));
        tbl[1] = mk("fetch_iss", 1, 32'h100, 0, 0, 0, 0, 0, 0, 0,
                    pk(1, 0, 4'hF, 32'h100, 0, 0, 0, 0, 0, 0));
        tbl[2] = mk("fetch_rsp", 1, 32'h100, 0, 0, 0, 0, 0, 1, 32'h00500093,
                    pk(0, 0, 4'hF, 32'h100, 0, 1, 32'h00500093, 0, 0, 0));
        tbl[3] = mk("wr_req", 0, 0, 1, 1, 4'h3, 32'h2004, 32'hDEADBEEF, 0, 0,
                    pk(0, 0, 4'hF, 32'h100, 0, 0, 0, 0, 0, 0));
        tbl[4] = mk("wr_iss", 0, 0, 1, 1, 4'h3, 32'h2004, 32'hDEADBEEF, 0, 0,
                    pk(1, 1, 4'h3, 32'h2004, 32'hDEADBEEF, 0, 0, 0, 0, 0));
        tbl[5] = mk("wr_rsp", 0, 0, 1, 1, 4'h3, 32'h2004, 32'hDEADBEEF, 1, 32'h55,
                    pk(0, 1, 4'h3, 32'h2004, 32'hDEADBEEF, 0, 0, 1, 32'h55, 0));
        tbl[6] = mk("idle_rsp", 0, 0, 0, 0, 0, 0, 0, 1, 32'h77,
                    pk(0, 1, 4'h3, 32'h2004, 32'hDEADBEEF, 0, 0, 0, 0, 0));
        tbl[7] = mk("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0,
                    pk(0, 1, 4'h3, 32'h2004, 32'hDEADBEEF, 0, 0, 0, 0, 0));

        do_reset();
        sample();
        chk("reset_state", outs(), '0);

        foreach (tbl[i]) begin
            tick();
            ireq = tbl[i].ireq; iaddr = tbl[i].iaddr; dreq = tbl[i].dreq;
            dwe = tbl[i].dwe; dbe = tbl[i].dbe; daddr = tbl[i].daddr;
            dwdata = tbl[i].dwdata; mrv = tbl[i].mrv; mrdata = tbl[i].mrd;
            sample();
            chk(tbl[i].name, outs(), tbl[i].exp);
        end

        // Tie straight out of reset: 1-cycle memory, grants must go I, D, I, D
        do_reset();
        tick();
        ireq = 1; iaddr = 32'hA0; dreq = 1; daddr = 32'hD0; dwe = 0; dbe = 4'hF;
        for (int k = 0; k < 12; k++) begin
            if (k > 0) tick();
            mrv = (k % 3 == 2); mrdata = k;
            sample();
            chk("tie_ctrl", 137'({mreq, irv, drv}),
                137'({k % 3 == 1, (k % 3 == 2) && ((k / 3) % 2 == 0),
                      (k % 3 == 2) && ((k / 3) % 2 == 1)}));
            if (k % 3 == 1)
                chk("tie_grant", 137'(maddr), ((k / 3) % 2 == 0) ? 137'(32'hA0) : 137'(32'hD0));
        end
        tick();
        idle_inputs();

        // Reset asserted during a data transaction
        tick();
        dreq = 1; daddr = 32'h600; dwe = 1; dbe = 4'h1; dwdata = 32'h99;
        sample();
        tick();
        sample();
        chk("rst_iss", 137'({mreq, maddr}), 137'({1'b1, 32'h600}));
        tick();
        #2 arstn = 1'b0;
        #1;
        chk("rst_async", outs(), '0);
        mrv = 1; mrdata = 32'hBAD;
        #1;
        chk("rst_rsp", 137'({irv, drv}), '0);
        tick();
        tick();
        arstn = 1'b1; dreq = 0; ireq = 0; mrv = 1; mrdata = 32'hBAD;
        sample();
        chk("late_rsp", outs(), '0);
        tick();
        mrv = 0; ireq = 1; iaddr = 32'h700; dreq = 1; daddr = 32'h800; dwe = 0;
        sample();
        tick();
        sample();
        chk("first_tie", 137'({mreq, mwe, maddr}), 137'({1'b1, 1'b0, 32'h700}));
        tick();
        mrv = 1; mrdata = 32'h42;
        sample();
        chk("first_tie_rsp", 137'({irv, ird, drv}), 137'({1'b1, 32'h42, 1'b0}));
        tick();
        idle_inputs();

        // Response arrives on the exact timeout cycle
        do_reset();
        tick();
        dreq = 1; daddr = 32'h300; dwe = 0; dbe = 4'hF;
        sample();
        tick();
        sample();
        chk("race_iss", 137'({mreq, maddr}), 137'({1'b1, 32'h300}));
        for (int k = 2; k <= 5; k++) begin
            tick();
            mrv = (k == 5); mrdata = (k == 5) ? 32'h1234 : 32'h0;
            sample();
            chk("race_rsp", 137'({drv, drd}), (k == 5) ? 137'({1'b1, 32'h1234}) : '0);
        end
        tick();
        idle_inputs();
        sample();
        chk("race_no_err", 137'(err), '0);

        // Silent memory: abort on the 4th cycle after issue
        tick();
        dreq = 1; daddr = 32'h400; dwe = 0; dbe = 4'hF;
        sample();
        tick();
        sample();
        chk("silent_iss", 137'({mreq, maddr}), 137'({1'b1, 32'h400}));
        for (int k = 2; k <= 5; k++) begin
            tick();
            mrdata = 32'hFFFF_0000;
            sample();
            chk("silent_abort", 137'({drv, drd, err}), (k == 5) ? 137'({1'b1, 32'h0, 1'b0}) : '0);
        end
        tick();
        idle_inputs();
        sample();
        chk("silent_err", 137'({err, drv}), 137'({1'b1, 1'b0}));
        tick();
        ireq = 1; iaddr = 32'h500;
        sample();
        tick();
        sample();
        chk("after_err_iss", 137'({mreq, maddr, mbe}), 137'({1'b1, 32'h500, 4'hF}));
        tick();
        mrv = 1; mrdata = 32'hCAFE;
        sample();
        chk("after_err_rsp", 137'({irv, ird, err}), 137'({1'b1, 32'hCAFE, 1'b1}));
        tick();
        idle_inputs();
        sample();
        chk("err_sticky", 137'(err), 137'(1));

        // Randomized traffic against a transaction-level model
        do_reset();
        owner = 0; issue_cyc = 0; cyc = 0; last_data = 1; ipend = 0; dpend = 0;
        m_req = 0; m_we = 0; m_be = 0; m_addr = 0; m_wdata = 0; m_err = 0;
        pia = 0; pda = 0; pwd = 0; pwe = 0; pbe = 0;
        for (int n = 0; n < 2000; n++) begin
            tick();
            if (!ipend && $urandom_range(0, 2) == 0) begin
                ipend = 1; pia = $urandom;
            end
            if (!dpend && $urandom_range(0, 2) == 0) begin
                dpend = 1; pda = $urandom; pwd = $urandom;
                pwe = 1'($urandom_range(0, 1)); pbe = 4'($urandom_range(0, 15));
            end
            ireq = ipend; iaddr = pia;
            dreq = dpend; daddr = pda; dwdata = pwd; dwe = pwe; dbe = pbe;
            mrv = (owner != 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
            mrdata = $urandom;

            age   = cyc - issue_cyc;
            fin   = (owner != 0) && (mrv || age == TO);
            e_irv = (owner == 1) && fin;
            e_drv = (owner == 2) && fin;
            e_ird = (owner == 1 && mrv) ? mrdata : 32'h0;
            e_drd = (owner == 2 && mrv) ? mrdata : 32'h0;
            sample();
            chk("rand", outs(), pk(m_req, m_we, m_be, m_addr, m_wdata,
                                   e_irv, e_ird, e_drv, e_drd, m_err));

            if (owner != 0 && age == TO && !mrv) m_err = 1;
            m_req = 0;
            if (owner != 0) begin
                if (fin) owner = 0;
            end else if (ipend || dpend) begin
                m_req = 1;
                issue_cyc = cyc + 1;
                if (ipend && (!dpend || last_data)) begin
                    owner = 1; last_data = 0;
                    m_we = 0; m_be = 4'hF; m_addr = pia; m_wdata = 0;
                end else begin
                    owner = 2; last_data = 1;
                    m_we = pwe; m_be = pbe; m_addr = pda; m_wdata = pwd;
                end
            end
            if (e_irv) ipend = 0;
            if (e_drv) dpend = 0;
            cyc++;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rv_mem_arbiter.md
# rv_mem_arbiter

Two-requester arbiter that shares one single-port memory between the core's instruction-fetch port and its data port, using the core's req/rvalid protocol on all three sides. It is used in unified-memory builds, where a single `rv_ram` holds both code and data. It sits between `rv_core` (or the data-side `rv_mmu`) and the memory. It serialises accesses with round-robin priority and one outstanding transaction, and a watchdog terminates transactions the memory never answers.

## Interface
- `XLEN`, from `rv_pkg`, sets the data and address width.
- `TIMEOUT`, default 15, is the number of cycles after issue that the arbiter waits for `mem_rvalid_i` before aborting. Legal range is 1..255.
- `clk_i`, input, 1: the single clock.
- `arstn_i`, input, 1: reset. Asynchronous, active-low.
- `instr_req_i`, input, 1: fetch request. Held high with a stable address until `instr_rvalid_o`.
- `instr_addr_i`, input, XLEN: fetch byte address.
- `instr_rvalid_o`, output, 1: one-cycle fetch completion pulse.
- `instr_rdata_o`, output, XLEN: fetch data. Valid only with `instr_rvalid_o`.
- `data_req_i`, input, 1: data request. Held high with stable attributes until `data_rvalid_o`.
- `data_we_i`, input, 1: 1 means write, 0 means read.
- `data_be_i`, input, XLEN/8: byte enables.
- `data_addr_i`, input, XLEN: data byte address.
- `data_wdata_i`, input, XLEN: write data.
- `data_rvalid_o`, output, 1: one-cycle data completion pulse. It pulses for writes too.
- `data_rdata_o`, output, XLEN: read data. Valid only with `data_rvalid_o`.
- `mem_req_o`, output, 1: one-cycle request pulse to the memory. Registered.
- `mem_we_o`, output, 1: memory write enable. Registered.
- `mem_be_o`, output, XLEN/8: memory byte enables. Registered.
- `mem_addr_o`, output, XLEN: memory address. Registered.
- `mem_wdata_o`, output, XLEN: memory write data. Registered.
- `mem_rvalid_i`, input, 1: memory completion pulse.
- `mem_rdata_i`, input, XLEN: memory read data.
- `bus_err_o`, output, 1: sticky flag, set on any timeout. Cleared only by reset.

## Operation
- The FSM has three states: `IDLE`, `WAIT_I` and `WAIT_D`. At most one transaction is outstanding.
- In `IDLE`, arbitration between pending requests works as follows:
  - If only one port is requesting, that port is granted.
  - If both are requesting, the port not granted last time wins. The `last_grant` bit resets to data, so instruction fetch wins the first tie.
- On a grant, the arbiter does the following in the same edge:
  - registers the `mem_*` signals from the granted port;
  - pulses `mem_req_o` for exactly one cycle;
  - updates `last_grant`;
  - clears the watchdog counter;
  - moves to `WAIT_I` or `WAIT_D`.
- Fetches are always reads: `mem_we_o` is 0 and `mem_be_o` is all ones. `mem_wdata_o` is 0.
- Outside the issue cycle, `mem_req_o` is 0. The other `mem_*` outputs hold their last value.
- In a `WAIT_x` state, a `mem_rvalid_i` pulse completes the transaction:
  - `x_rvalid_o` is driven combinationally as `mem_rvalid_i` while in `WAIT_x`;
  - `x_rdata_o` is `mem_rdata_i` in that cycle and 0 otherwise;
  - the FSM returns to `IDLE` on the next edge.
- A `mem_rvalid_i` pulse while in `IDLE` is ignored and is not forwarded.
- A request that is still high in the `IDLE` cycle after completion is treated as a new request.
- Watchdog:
  - An 8-bit counter increments every cycle spent in `WAIT_x` without `mem_rvalid_i`.
  - When it reaches `TIMEOUT`, the arbiter pulses `x_rvalid_o` with `x_rdata_o` = 0, sets `bus_err_o`, and returns to `IDLE`.
  - A `mem_rvalid_i` arriving in the same cycle as the timeout takes precedence: the transaction completes normally, without an error.
- The arbiter never sends a request to the memory while a transaction is outstanding.

## Timing
- Reset values: all outputs 0, state `IDLE`, `last_grant` = data, counter 0.
- Reset asserted in mid-transaction aborts the transaction without any completion pulse. Any memory response that arrives after reset is ignored.
- Latency with a 1-cycle memory:
  - cycle 0: request seen in `IDLE`;
  - cycle 1: `mem_req_o` high;
  - cycle 2: `mem_rvalid_i`, and `x_rvalid_o` in the same cycle.
- Issue-to-issue spacing is at least 3 cycles: issue, wait, then `IDLE`.
- Under continuous requests from both ports, grants alternate I, D, I, D and so on. Neither port waits more than one transaction.
- Timeout: the abort pulse occurs in the `TIMEOUT`-th cycle after the issue cycle.
- Requesters must not change their address or attributes while their request is pending. Doing so is a protocol violation, and the result is undefined.

## Test plan
- Single fetch: `instr_req_i` = 1, `instr_addr_i` = 0x100, memory returns 0x00500093 one cycle after issue. Required: `mem_req_o` in cycle 1 with addr 0x100, `we` 0 and `be` 0xF; `instr_rvalid_o` in cycle 2 with rdata 0x00500093; `data_rvalid_o` stays 0.
- Data write: `data_req_i` = 1, `we` = 1, `be` = 0x3, addr 0x2004, wdata 0xDEADBEEF. Required: those values appear on `mem_*` with a one-cycle `mem_req_o`; `data_rvalid_o` pulses once.
- Simultaneous requests straight out of reset, both held for 4 transactions. Required: grant order I, D, I, D, with exactly one outstanding transaction at any time.
- Silent memory with `TIMEOUT` = 4 and `mem_rvalid_i` never asserted. Required: `data_rvalid_o` pulses 4 cycles after issue with rdata 0; `bus_err_o` rises and stays 1; the next request is served normally.
- Response and timeout in the same cycle: `mem_rvalid_i` arrives exactly at the `TIMEOUT` count with rdata 0x1234. Required: the completion carries 0x1234 and `bus_err_o` stays 0.
- Reset during `WAIT_D`: all outputs go to 0 immediately. A late `mem_rvalid_i` after reset release produces no `rvalid`, and the first tie after reset is granted to instruction fetch.
